// File: rtl/edge_window_ctrl.sv
// ============================================================================
// Module  : edge_window_ctrl
// Brief   : Line-buffer and 5x5 window sequencer for a combinational kernel.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_window_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [7:0]   s_data,
  output logic [199:0] k_window,
  input  logic [7:0]   k_pixel,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [7:0]   m_data,
  output logic         m_first,
  output logic         m_last,
  output logic         frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]  r_col;
  logic [RW-1:0]  r_row;
  logic [199:0]   r_win;
  logic           r_m_valid;
  logic           r_m_first;
  logic           r_m_last;
  logic           r_frame_done;

  logic [7:0]     r_lb0 [IMG_W];
  logic [7:0]     r_lb1 [IMG_W];
  logic [7:0]     r_lb2 [IMG_W];
  logic [7:0]     r_lb3 [IMG_W];

  logic           w_accept;
  logic           w_col_last;
  logic           w_row_last;
  logic           w_win_ok;
  logic [7:0]     w_newpix [5];

  // clr forces s_ready low so a same-cycle pixel is dropped rather than accepted
  assign s_ready    = (!r_m_valid || m_ready) && !clr;
  assign w_accept   = s_valid && s_ready;
  assign w_col_last = (r_col == CW'(IMG_W - 1));
  assign w_row_last = (r_row == RW'(IMG_H - 1));
  assign w_win_ok   = (r_row >= RW'(4)) && (r_col >= CW'(4));

  // Row 4 (newest) is the incoming pixel; row 0 comes from the oldest buffer
  always_comb begin
    w_newpix[4] = s_data;
    w_newpix[3] = r_lb0[r_col];
    w_newpix[2] = r_lb1[r_col];
    w_newpix[1] = r_lb2[r_col];
    w_newpix[0] = r_lb3[r_col];
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb3[r_col] <= r_lb2[r_col];
      r_lb2[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= r_lb0[r_col];
      r_lb0[r_col] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_win        <= '0;
      r_m_valid    <= 1'b0;
      r_m_first    <= 1'b0;
      r_m_last     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= r_m_valid && m_ready && r_m_last;
      if (clr) begin
        r_col     <= '0;
        r_row     <= '0;
        r_m_valid <= 1'b0;
      end else if (w_accept) begin
        for (int r = 0; r < 5; r++) begin
          r_win[40*r +: 40] <= {w_newpix[r], r_win[40*r+8 +: 32]};
        end
        r_m_valid <= w_win_ok;
        r_m_first <= (r_row == RW'(4)) && (r_col == CW'(4));
        r_m_last  <= w_row_last && w_col_last;
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign k_window   = r_win;
  assign m_data     = k_pixel;
  assign m_valid    = r_m_valid;
  assign m_first    = r_m_first;
  assign m_last     = r_m_last;
  assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_edge_window_ctrl.sv
// ============================================================================
// Module  : tb_edge_window_ctrl
// Brief   : Scoreboard bench for edge_window_ctrl with a 5x5 gradient kernel.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_edge_window_ctrl;

  localparam int W = 8;
  localparam int H = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic         s_valid;
  logic         s_ready;
  logic [7:0]   s_data;
  logic [199:0] k_window;
  logic [7:0]   k_pixel;
  logic         m_valid;
  logic         m_ready;
  logic [7:0]   m_data;
  logic         m_first;
  logic         m_last;
  logic         frame_done;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       l;
  } exp_t;

  exp_t q[$];
  int   img [H][W];
  int   checks = 0;
  int   errors = 0;
  int   fd_cnt = 0;
  int   exp_frames = 0;
  int   rdy_mode = 0;

  edge_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .k_window(k_window), .k_pixel(k_pixel),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_first(m_first), .m_last(m_last), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic int rw(input int r);
    case (r)
      0, 4:    return 1;
      1, 3:    return 4;
      default: return 6;
    endcase
  endfunction

  function automatic int cw(input int c);
    case (c)
      0:       return -1;
      1:       return -2;
      3:       return 2;
      4:       return 1;
      default: return 0;
    endcase
  endfunction

  // Kernel stand-in: separable 5x5 horizontal gradient, truncated to 8 bits
  function automatic logic [7:0] kern(input logic [199:0] w);
    int acc = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        acc += rw(r) * cw(c) * int'(w[40*r+8*c +: 8]);
    return acc[7:0];
  endfunction

  always_comb k_pixel = kern(k_window);

  // Reference: gradient of the image neighbourhood whose bottom-right is (r,c)
  function automatic logic [7:0] exp_pix(input int r, input int c);
    int acc = 0;
    for (int dy = 0; dy < 5; dy++)
      for (int dx = 0; dx < 5; dx++)
        acc += rw(dy) * cw(dx) * img[r-4+dy][c-4+dx];
    return acc[7:0];
  endfunction

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        2:       m_ready = 1'b0;
        default: m_ready = 1'($urandom % 2);
      endcase
    end
  end

  // Monitor: handshake scoreboard, stall hold, s_ready rule, frame_done timing
  logic         prev_stall = 1'b0;
  logic         prev_hs_last = 1'b0;
  logic [210:0] saved;
  exp_t         e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall   = 1'b0;
      prev_hs_last = 1'b0;
    end else begin
      checks++;
      if (frame_done !== prev_hs_last) begin
        errors++;
        $display("FAIL frame_done: got %b expected %b at %0t", frame_done, prev_hs_last, $time);
      end
      if (frame_done === 1'b1) fd_cnt++;
      checks++;
      if (s_ready !== ((!m_valid || m_ready) && !clr)) begin
        errors++;
        $display("FAIL s_ready: got %b expected %b at %0t", s_ready, (!m_valid || m_ready) && !clr, $time);
      end
      if (prev_stall) begin
        checks++;
        if ({k_window, m_data, m_first, m_last} !== saved) begin
          errors++;
          $display("FAIL stall_hold: window/data/first/last changed during stall at %0t", $time);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got data %h first %b last %b, expected none at %0t", m_data, m_first, m_last, $time);
        end else begin
          e = q.pop_front();
          if ({m_data, m_first, m_last} !== {e.d, e.f, e.l}) begin
            errors++;
            $display("FAIL output: got data %h first %b last %b, expected data %h first %b last %b at %0t",
                     m_data, m_first, m_last, e.d, e.f, e.l, $time);
          end
        end
      end
      prev_stall   = m_valid && !m_ready;
      saved        = {k_window, m_data, m_first, m_last};
      prev_hs_last = m_valid && m_ready && m_last;
    end
  end

  task automatic check(input string name, input logic [199:0] got, input logic [199:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic send_pixel(input int r, input int c, input bit gaps);
    int n = 0;
    if (gaps && ($urandom % 2 == 1)) begin
      s_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = 8'(img[r][c]);
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 1000);
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got s_ready 0 expected 1 at pixel (%0d,%0d)", r, c);
    end else if (r >= 4 && c >= 4) begin
      q.push_back('{d: exp_pix(r, c), f: (r == 4 && c == 4), l: (r == H-1 && c == W-1)});
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // kind: 0 constant, 1 horizontal ramp, 2 vertical ramp, 3 random
  task automatic send_frame(input int kind, input int val, input bit gaps, input int npix);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0:       img[r][c] = val;
          1:       img[r][c] = c;
          2:       img[r][c] = r;
          default: img[r][c] = int'($urandom % 256);
        endcase
    for (int i = 0; i < npix; i++) send_pixel(i / W, i % W, gaps);
    if (npix == W * H) exp_frames++;
  endtask

  task automatic drain();
    int n = 0;
    rdy_mode = 0;
    while (q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_queue_empty", 200'(q.size()), 200'd0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_k_window", k_window, 200'd0);
    check("reset_outputs", 200'({m_valid, m_first, m_last, frame_done}), 200'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    send_frame(0, 50, 1'b0, W*H);
    send_frame(1, 0, 1'b0, W*H);
    send_frame(2, 0, 1'b0, W*H);
    drain();

    rdy_mode = 1;
    send_frame(3, 0, 1'b1, W*H);
    send_frame(1, 0, 1'b1, W*H);
    drain();

    send_frame(3, 0, 1'b0, W*H);
    send_frame(0, 200, 1'b0, W*H);
    drain();

    send_frame(3, 0, 1'b0, 20);
    s_valid = 1'b1;
    s_data  = 8'hAA;
    clr     = 1'b1;
    @(negedge clk);
    check("clr_s_ready", 200'(s_ready), 200'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    s_valid = 1'b0;
    check("clr_m_valid", 200'(m_valid), 200'd0);
    send_frame(1, 0, 1'b0, W*H);
    drain();

    // Asynchronous reset while an output is stalled
    send_frame(3, 0, 1'b0, 4*W + 4);
    @(negedge clk);
    rdy_mode = 2;
    @(posedge clk);
    #2;
    send_pixel(4, 4, 1'b0);
    @(posedge clk);
    #2;
    check("pre_reset_m_valid", 200'(m_valid), 200'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_m_valid", 200'(m_valid), 200'd0);
    q.delete();
    repeat (2) @(negedge clk);
    check("reset2_k_window", k_window, 200'd0);
    @(posedge clk);
    #1;
    rdy_mode = 0;
    rst_n = 1'b1;
    send_frame(1, 0, 1'b0, W*H);
    drain();

    check("frame_done_count", 200'(fd_cnt), 200'(exp_frames));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/edge_window_ctrl.md
Name: edge_window_ctrl

Overview:
- Sequencer for the team's combinational 5x5 horizontal-gradient kernel (200-bit window in, 8-bit pixel out).
- Accepts a raster pixel stream and keeps four line buffers plus a 5x5 window shift register.
- Presents each fully populated window to the kernel and returns the kernel result on a valid/ready output stream.
- Produces a valid-only convolution: output frame is (IMG_W-4) x (IMG_H-4).

Parameters:
- IMG_W, 64, pixels per line; legal range 5..1024.
- IMG_H, 64, lines per frame; legal range 5..1024.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous frame abort; clears counters and m_valid. Line-buffer contents are not cleared.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input pixel ready.
- s_data  in  8  input pixel, raster order, unsigned.
- k_window  out  200  window to kernel: row r (0 = oldest/top) at bits [40r+39:40r]; column c (0 = leftmost) at [40r+8c+7 : 40r+8c].
- k_pixel  in  8  kernel result, combinational from k_window.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  output pixel ready.
- m_data  out  8  output pixel; equals k_pixel.
- m_first  out  1  qualifies the first output pixel of a frame.
- m_last  out  1  qualifies the last output pixel of a frame.
- frame_done  out  1  one-cycle pulse when the last output pixel is accepted.

Behaviour:
- Reset (rst_n low, asynchronous): col=0, row=0, m_valid=0, m_first=0, m_last=0, frame_done=0, window register all zero, so k_window=0. Line buffers are not reset.
- Input acceptance:
  - s_ready = !m_valid || m_ready.
  - An accept is s_valid && s_ready. With no accept, all state holds.
- On an accept of pixel p at position (row, col):
  - New column {row4..row0} = {p, lb0[col], lb1[col], lb2[col], lb3[col]}, where lb3 is oldest.
  - Line buffers shift: lb3[col]<=lb2[col], lb2[col]<=lb1[col], lb1[col]<=lb0[col], lb0[col]<=p.
  - Window shifts one column left: column 0 is dropped and the new column enters column 4.
  - col increments; at IMG_W-1 it wraps to 0 and row increments. At (IMG_H-1, IMG_W-1), both wrap to 0 and a new frame begins with no gap cycle.
- Output:
  - m_valid is registered. The next cycle it is set to (row>=4 && col>=4) evaluated at the accept.
  - If that condition is false: m_valid<=0 when m_ready, or stays 0.
  - m_first is registered alongside m_valid: 1 when the accept was at (4,4).
  - m_last is registered alongside m_valid: 1 when the accept was at (IMG_H-1, IMG_W-1).
  - Latency is 1 cycle from the accept of the window-completing pixel to m_valid.
- Hold under stall: while m_valid && !m_ready, s_ready=0. k_window, m_data, m_first and m_last stay stable.
- Throughput: 1 pixel per cycle when s_valid and m_ready are continuously high. Simultaneous output handshake and new accept in the same cycle is legal.
- frame_done pulses for 1 cycle, the cycle after m_valid && m_ready && m_last.
- clr:
  - Takes priority over an accept in the same cycle; the pixel is dropped, because s_ready is forced to 0 while clr=1.
  - Sets row=0, col=0, m_valid=0.
  - Applied mid-frame, the next accepted pixel is treated as frame pixel (0,0). Stale line-buffer data never reaches m_data, because windows are suppressed until row>=4.
- Arithmetic: none in this block. k_pixel is passed through unchanged; its width and truncation are owned by the kernel.
- Line buffers: four IMG_W x 8 arrays with one read and one write per cycle at the same address (read-before-write), mappable to distributed or block RAM.

Test Plan:
- IMG_W=8, IMG_H=6, constant image 50, kernel instantiated, m_ready=1 -> exactly 8 outputs, all 0x00. m_first on output 1, m_last on output 8, one frame_done pulse, no output bubbles once row 4 is reached.
- Horizontal ramp p=col (8x6) -> every output 0x80, i.e. 16*8 truncated to 8 bits. Vertical ramp p=row -> every output 0x00.
- Same frame with m_ready toggling pseudo-randomly (about 50%) -> identical output sequence. s_ready=0 exactly when m_valid && !m_ready. k_window stable during stalls.
- Two back-to-back frames, the second with constant 200 -> second frame yields 8 outputs of 0x00 with correct m_first/m_last, and no output from rows 0-3 of frame 2.
- clr pulsed after 20 accepts, then a full 8x6 ramp frame -> no output before the new frame's (4,4). Then 8 outputs of 0x80. Also assert rst_n low mid-frame: m_valid=0 immediately, with no clock edge needed.
